// File: rtl/sr_input_pkg.sv
// sr_input_pkg
// Shared definitions for the push-button conditioning logic that feeds
// sr_latch: the per-channel debounce FSM state encoding and the default
// debounce parameters.
//   LOW       - debounced level is 0 and the synchronised input agrees
//   WAIT_HIGH - input went high, counting stable cycles before accepting
//   HIGH      - debounced level is 1 and the synchronised input agrees
//   WAIT_LOW  - input went low, counting stable cycles before accepting
package sr_input_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch
// One button channel: 2-flop synchroniser, a debounce FSM with a stable-level
// register and a cycle counter. A level change is accepted only after the
// synchronised input has differed from the stable level for DEBOUNCE_CYCLES
// consecutive edges; any return to the old level restarts the count.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   raw_in     - raw button input, asynchronous to clk
//   level      - debounced level (registered)
//   rise, fall - combinational, high during the cycle whose closing edge
//                flips level up / down, so a consumer registering on that
//                same edge lines up with the level change
module debounce_ch
  import sr_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e       state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= LOW;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Counter is zero outside the WAIT states, so it defaults to 0 and is only
  // loaded where a count is in progress.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    state_d  = state_q;
    rise     = 1'b0;
    fall     = 1'b0;
    case (state_q)
      LOW: begin
        if (sync2_q != stable_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        if (sync2_q != stable_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (sync2_q == stable_q) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = 1'b1;
          state_d  = HIGH;
          rise     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync2_q == stable_q) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = 1'b0;
          state_d  = LOW;
          fall     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
  end

  assign level = stable_q;

endmodule

// File: rtl/sr_button_conditioner.sv
// sr_button_conditioner
// Turns the raw set and reset push buttons into clean one-cycle S/R pulses
// for sr_latch. Each button is debounced by a debounce_ch instance; a pulse
// is issued only on a debounced press, and only when the other button's
// debounced level is low after the same edge, so S and R are never high
// together. Suppressed presses raise conflict for one cycle.
// Ports:
//   clk, rst_n             - clock and asynchronous active-low reset
//   set_btn, reset_btn     - raw buttons, active high, asynchronous
//   S, R                   - one-cycle set / reset pulses to sr_latch
//   set_level, reset_level - debounced button levels
//   conflict               - one-cycle flag for a suppressed press
module sr_button_conditioner
  import sr_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic set_level,
  output logic reset_level,
  output logic conflict
);

  logic set_rise, set_fall;
  logic reset_rise, reset_fall;
  logic set_level_next, reset_level_next;
  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_ch (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(set_btn),
    .level (set_level),
    .rise  (set_rise),
    .fall  (set_fall)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_reset_ch (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(reset_btn),
    .level (reset_level),
    .rise  (reset_rise),
    .fall  (reset_fall)
  );

  // Arbitration looks at each channel's level as it will be after this edge,
  // so a simultaneous rise on the other channel blocks the pulse while a
  // simultaneous fall on the other channel lets it through.
  always_comb begin
    set_level_next   = set_level ^ (set_rise | set_fall);
    reset_level_next = reset_level ^ (reset_rise | reset_fall);
    s_d        = set_rise & ~reset_level_next;
    r_d        = reset_rise & ~set_level_next;
    conflict_d = (set_rise & reset_level_next) | (reset_rise & set_level_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_button_conditioner.sv
// tb_sr_button_conditioner
// Drives sr_button_conditioner with DEBOUNCE_CYCLES=4, so a debounced flip
// (and any pulse) appears after edge 5 counted from the edge that first
// samples the new raw level. Inputs change 1 time unit after a rising edge,
// outputs are compared 1 time unit after the following rising edge.
module tb_sr_button_conditioner;

  localparam int N    = 4;
  localparam int FLIP = N + 1;
  localparam int NONE = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic S, R, set_level, reset_level, conflict;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic set_btn;
    logic reset_btn;
    logic rst_n;
    logic exp_s;
    logic exp_r;
    logic exp_conflict;
    logic exp_set_level;
    logic exp_reset_level;
  } vec_t;

  vec_t vecs[$];

  sr_button_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_btn    (set_btn),
    .reset_btn  (reset_btn),
    .S          (S),
    .R          (R),
    .set_level  (set_level),
    .reset_level(reset_level),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs, let one rising edge happen, settle.
  task automatic apply_stimulus(input logic sb, input logic rb, input logic rn);
    set_btn   = sb;
    reset_btn = rb;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0b, expected %0b", tag, cyc, act, exp);
    end
  endtask

  // Compare all outputs after one cycle, plus the S/R exclusivity property.
  task automatic check_output(input string tag, input int cyc, input logic es, input logic er,
                              input logic ec, input logic esl, input logic erl);
    check_bit({tag, ".S"}, cyc, S, es);
    check_bit({tag, ".R"}, cyc, R, er);
    check_bit({tag, ".conflict"}, cyc, conflict, ec);
    check_bit({tag, ".set_level"}, cyc, set_level, esl);
    check_bit({tag, ".reset_level"}, cyc, reset_level, erl);
    check_bit({tag, ".s_r_exclusive"}, cyc, S & R, 1'b0);
  endtask

  // Hold constant buttons for a number of cycles; the levels switch from
  // their "before" to "after" values at cycle flip_k, where the one-cycle
  // pulses are also expected.
  task automatic run_phase(input string tag, input logic sb, input logic rb, input logic rn,
                           input int cycles, input int flip_k,
                           input logic sp, input logic rp, input logic cp,
                           input logic sl0, input logic sl1, input logic rl0, input logic rl1);
    for (int k = 0; k < cycles; k++) begin
      apply_stimulus(sb, rb, rn);
      check_output(tag, k, (k == flip_k) ? sp : 1'b0, (k == flip_k) ? rp : 1'b0,
                   (k == flip_k) ? cp : 1'b0,
                   (k >= flip_k) ? sl1 : sl0, (k >= flip_k) ? rl1 : rl0);
    end
  endtask

  function automatic vec_t mk(input logic sb, input logic rb, input logic rn, input logic es,
                              input logic er, input logic ec, input logic esl, input logic erl);
    vec_t v;
    v.set_btn = sb; v.reset_btn = rb; v.rst_n = rn;
    v.exp_s = es; v.exp_r = er; v.exp_conflict = ec;
    v.exp_set_level = esl; v.exp_reset_level = erl;
    return v;
  endfunction

  initial begin
    // Table: reset with toggling buttons, idle after reset, clean set press
    // and release, then a simultaneous press and release of both buttons.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(k[0], ~k[0], 1'b0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, k == FLIP, 0, 0, k >= FLIP, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 0, 0, 0, k < FLIP, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 0, 0, k == FLIP, k >= FLIP, k >= FLIP));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 0, 0, 0, k < FLIP, k < FLIP));

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].set_btn, vecs[i].reset_btn, vecs[i].rst_n);
      check_output("table", i, vecs[i].exp_s, vecs[i].exp_r, vecs[i].exp_conflict,
                   vecs[i].exp_set_level, vecs[i].exp_reset_level);
    end

    // Bounce: high 3, low 1, high 8. The low glitch restarts the count, so
    // the single pulse lands 5 edges after the final rise (cycle 4 + 5 = 9).
    $display("[TB] bounce sequence");
    run_phase("bounce_hi1", 1, 0, 1, 3, NONE, 0, 0, 0, 0, 0, 0, 0);
    run_phase("bounce_lo", 0, 0, 1, 1, NONE, 0, 0, 0, 0, 0, 0, 0);
    run_phase("bounce_hi2", 1, 0, 1, 8, FLIP, 1, 0, 0, 0, 1, 0, 0);
    run_phase("bounce_rel", 0, 0, 1, 8, FLIP, 0, 0, 0, 1, 0, 0, 0);

    // Held interlock: reset pressed alone (R pulse), then set pressed while
    // reset is held (suppressed, conflict), then both released, then a clean
    // set press.
    $display("[TB] held interlock sequence");
    run_phase("lock_rst", 0, 1, 1, 8, FLIP, 0, 1, 0, 0, 0, 0, 1);
    run_phase("lock_set", 1, 1, 1, 8, FLIP, 0, 0, 1, 0, 1, 1, 1);
    run_phase("lock_relr", 1, 0, 1, 8, FLIP, 0, 0, 0, 1, 1, 1, 0);
    run_phase("lock_rels", 0, 0, 1, 8, FLIP, 0, 0, 0, 1, 0, 0, 0);
    run_phase("lock_set2", 1, 0, 1, 8, FLIP, 1, 0, 0, 0, 1, 0, 0);
    run_phase("lock_rel2", 0, 0, 1, 8, FLIP, 0, 0, 0, 1, 0, 0, 0);

    // Reset mid-count: the debounce is aborted, and the held button is seen
    // as a fresh press after reset release with the full latency.
    $display("[TB] reset mid-count sequence");
    run_phase("mid_pre", 1, 0, 1, 3, NONE, 0, 0, 0, 0, 0, 0, 0);
    run_phase("mid_rst", 1, 0, 0, 2, NONE, 0, 0, 0, 0, 0, 0, 0);
    run_phase("mid_post", 1, 0, 1, 8, FLIP, 1, 0, 0, 0, 1, 0, 0);
    run_phase("mid_rel", 0, 0, 1, 8, FLIP, 0, 0, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
